// File: rtl/multdiv_seq_if.sv
// multdiv_seq_if: start/operand/result bundle between pipeline control and multdiv_seq
interface multdiv_seq_if #(parameter int WIDTH = 32);
  logic ctrl_MULT, ctrl_DIV;
  logic [WIDTH-1:0] data_operandA, data_operandB, data_result;
  logic data_exception, data_resultRDY;
  modport master(output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
                 input data_result, data_exception, data_resultRDY);
  modport slave(input ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
                output data_result, data_exception, data_resultRDY);
endinterface

// File: rtl/multdiv_seq.sv
// multdiv_seq: signed multicycle multiply/divide sharing one adder, one step per clock
module multdiv_seq #(parameter int WIDTH = 32) (
  input logic clock,
  input logic reset,
  multdiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_step, sh, prod;
  logic [WIDTH-1:0] m, ma, mb, res, res_nx, q;
  logic [WIDTH:0] base, addend, sum;
  logic neg, exc, exc_nx, start, last, is_div, div0;
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign ma = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mb = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign last = cnt == CW'(WIDTH-1);
  assign is_div = state == DIV;
  assign div0 = is_div && m == '0;
  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign sh = {p[2*WIDTH-2:0], 1'b0};
  assign base = is_div ? {1'b0, sh[2*WIDTH-1:WIDTH]} : {1'b0, p[2*WIDTH-1:WIDTH]};
  assign addend = is_div ? ~{1'b0, m} : (p[0] ? {1'b0, m} : '0);
  assign sum = base + addend + (WIDTH+1)'(is_div);
  assign p_step = is_div ? (sum[WIDTH] ? sh : {sum[WIDTH-1:0], sh[WIDTH-1:1], 1'b1})
                         : {sum, p[WIDTH-1:1]};
  assign prod = neg ? -p_step : p_step;
  assign q = neg ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
  assign bus.data_result = res;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = state == DONE;
  always_comb begin
    state_nx = start ? (bus.ctrl_MULT ? MUL : DIV)
             : state == MUL ? (last ? DONE : MUL)
             : is_div ? ((last || div0) ? DONE : DIV)
             : IDLE;
    res_nx = start ? '0
           : (state == MUL && last) ? prod[WIDTH-1:0]
           : div0 ? '0
           : (is_div && last) ? q
           : res;
    exc_nx = start ? 1'b0
           : (state == MUL && last) ? prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}}
           : div0 ? 1'b1
           : (is_div && last) ? p_step[WIDTH-1] & ~neg
           : exc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      res <= '0;
      exc <= 1'b0;
      p <= '0;
      m <= '0;
      neg <= 1'b0;
    end else begin
      state <= state_nx;
      res <= res_nx;
      exc <= exc_nx;
      if (start) begin
        cnt <= '0;
        p <= {{WIDTH{1'b0}}, bus.ctrl_MULT ? mb : ma};
        m <= bus.ctrl_MULT ? ma : mb;
        neg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      end else if (state == MUL || is_div) begin
        cnt <= cnt + 1'b1;
        p <= p_step;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed checks of latency, results and exceptions for multdiv_seq
module tb_multdiv_seq;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  int lat;
  logic [31:0] r;
  logic e;
  multdiv_seq_if #(.WIDTH(32)) bus();
  multdiv_seq #(.WIDTH(32)) dut(.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;

  // lat = cycles from the start cycle to the RDY cycle (100 = never arrived)
  task automatic run_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT = mul; bus.ctrl_DIV = div; bus.data_operandA = a; bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT = 0; bus.ctrl_DIV = 0; bus.data_operandA = 32'hdeadbeef; bus.data_operandB = 32'h1234567;
    lat = 1;
    while (!bus.data_resultRDY && lat < 100) begin @(negedge clk); lat++; end
    r = bus.data_result; e = bus.data_exception;
  endtask

  task automatic test_reset;
    rst = 1; bus.ctrl_MULT = 0; bus.ctrl_DIV = 0; bus.data_operandA = 0; bus.data_operandB = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    checks++; if (bus.data_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin fails++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY); end
  endtask

  task automatic test_mul;
    run_op(1, 0, 32'd7, -32'sd6);
    checks++; if (lat !== 33) begin fails++; $display("FAIL mul_lat: got %0d expected 33", lat); end
    checks++; if (r !== 32'hFFFFFFD6) begin fails++; $display("FAIL mul_7x-6: got %h expected ffffffd6", r); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL mul_7x-6_exc: got %b expected 0", e); end
    @(negedge clk);
    checks++; if (bus.data_resultRDY !== 1'b0) begin fails++; $display("FAIL rdy_pulse: got %b expected 0", bus.data_resultRDY); end
    run_op(1, 0, 32'h00010000, 32'h00010000);
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL mul_ovf: got %h expected 0", r); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL mul_ovf_exc: got %b expected 1", e); end
    run_op(1, 0, 32'h80000000, 32'd1);
    checks++; if (r !== 32'h80000000) begin fails++; $display("FAIL mul_min: got %h expected 80000000", r); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL mul_min_exc: got %b expected 0", e); end
    run_op(1, 0, 32'd0, -32'sd5);
    checks++; if (lat !== 33) begin fails++; $display("FAIL mul_zero_lat: got %0d expected 33", lat); end
    checks++; if (r !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL mul_zero: got %h/%b expected 0/0", r, e); end
    run_op(1, 0, -32'sd3, -32'sd1000);
    checks++; if (r !== 32'd3000 || e !== 1'b0) begin fails++; $display("FAIL mul_negneg: got %h/%b expected bb8/0", r, e); end
  endtask

  task automatic test_div;
    run_op(0, 1, -32'sd7, 32'd2);
    checks++; if (r !== 32'hFFFFFFFD || e !== 1'b0) begin fails++; $display("FAIL div_-7/2: got %h/%b expected fffffffd/0", r, e); end
    run_op(0, 1, 32'd100, -32'sd7);
    checks++; if (lat !== 33) begin fails++; $display("FAIL div_lat: got %0d expected 33", lat); end
    checks++; if (r !== 32'hFFFFFFF2 || e !== 1'b0) begin fails++; $display("FAIL div_100/-7: got %h/%b expected fffffff2/0", r, e); end
    run_op(0, 1, 32'h7FFFFFFF, 32'd3);
    checks++; if (r !== 32'h2AAAAAAA || e !== 1'b0) begin fails++; $display("FAIL div_max/3: got %h/%b expected 2aaaaaaa/0", r, e); end
  endtask

  task automatic test_div_zero;
    run_op(0, 1, 32'd5, 32'd0);
    checks++; if (lat !== 2) begin fails++; $display("FAIL div0_lat: got %0d expected 2", lat); end
    checks++; if (r !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL div0: got %h/%b expected 0/1", r, e); end
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF);
    checks++; if (lat !== 33) begin fails++; $display("FAIL div_ovf_lat: got %0d expected 33", lat); end
    checks++; if (r !== 32'h80000000 || e !== 1'b1) begin fails++; $display("FAIL div_ovf: got %h/%b expected 80000000/1", r, e); end
  endtask

  task automatic test_back_to_back;
    int rdys = 0;
    @(negedge clk);
    bus.ctrl_MULT = 1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd4;
    @(negedge clk);
    bus.ctrl_MULT = 0;
    for (int i = 1; i < 10; i++) begin if (bus.data_resultRDY) rdys++; @(negedge clk); end
    run_op(0, 1, 32'd100, 32'd7);
    checks++; if (lat !== 33) begin fails++; $display("FAIL abort_lat: got %0d expected 33", lat); end
    checks++; if (r !== 32'd14 || e !== 1'b0) begin fails++; $display("FAIL abort_result: got %h/%b expected e/0", r, e); end
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.data_resultRDY) rdys++; end
    checks++; if (rdys !== 0) begin fails++; $display("FAIL abort_extra_rdy: got %0d expected 0", rdys); end
    run_op(1, 1, 32'd5, 32'd3);
    checks++; if (r !== 32'd15 || lat !== 33) begin fails++; $display("FAIL both_pulses: got %h lat %0d expected f lat 33", r, lat); end
  endtask

  task automatic test_reset_mid;
    int rdys = 0;
    @(negedge clk);
    bus.ctrl_MULT = 1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
    @(negedge clk);
    bus.ctrl_MULT = 0;
    repeat (14) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (bus.data_result !== 32'h0 || bus.data_exception !== 1'b0) begin fails++; $display("FAIL midreset_out: got %h/%b expected 0/0", bus.data_result, bus.data_exception); end
    for (int i = 0; i < 40; i++) begin if (bus.data_resultRDY) rdys++; @(negedge clk); end
    checks++; if (rdys !== 0) begin fails++; $display("FAIL midreset_rdy: got %0d expected 0", rdys); end
    run_op(1, 0, 32'd2, 32'd3);
    checks++; if (r !== 32'd6 || lat !== 33) begin fails++; $display("FAIL post_reset_mul: got %h lat %0d expected 6 lat 33", r, lat); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
